uart_rx: RTL and testbench

- UART receiver. It is the far-end consumer of the serial stream produced by the transmitter block.
- Uses the same 16x-oversampled baud tick as the transmitter, recovers 8N1 frames from the line and presents each byte with a one-cycle done strobe.
- Output feeds the downstream byte consumer (command decoder / FIFO); rx_done maps one-to-one onto its write strobe.

---
 rtl/uart_rx.sv | 142 ++++++++++++++
 tb/tb_uart_rx.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// 8N1 UART receiver: 16x-oversampled, samples mid-bit, delivers each byte with
// a one-cycle rx_done strobe and a sticky-until-next-frame framing error flag.
module uart_rx #(
  parameter int DBIT    = 8,
  parameter int SB_TICK = 16
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            baud,
  input  logic            rx,
  output logic [DBIT-1:0] d_out,
  output logic            rx_done,
  output logic            frame_err
);

  localparam int            NW     = (DBIT > 1) ? $clog2(DBIT) : 1;
  localparam logic [3:0]    S_MID  = 4'd7;
  localparam logic [3:0]    S_LAST = 4'd15;
  localparam logic [3:0]    S_STOP = 4'(SB_TICK - 1);
  localparam logic [NW-1:0] N_LAST = NW'(DBIT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [3:0]      s_q, s_d;
  logic [NW-1:0]   n_q, n_d;
  logic [DBIT-1:0] sh_q, sh_d;
  logic [DBIT-1:0] d_out_q, d_out_d;
  logic            rx_done_q, rx_done_d;
  logic            frame_err_q, frame_err_d;
  logic [1:0]      sync_q, sync_d;
  logic            rx_s;

  // Line synchronizer resets to the idle (high) level so reset never looks like a start bit.
  assign sync_d = {sync_q[0], rx};
  assign rx_s   = sync_q[1];

  // State, counters, shift register, synchronizer and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      s_q         <= 4'd0;
      n_q         <= '0;
      sh_q        <= '0;
      d_out_q     <= '0;
      rx_done_q   <= 1'b0;
      frame_err_q <= 1'b0;
      sync_q      <= 2'b11;
    end else begin
      state_q     <= state_d;
      s_q         <= s_d;
      n_q         <= n_d;
      sh_q        <= sh_d;
      d_out_q     <= d_out_d;
      rx_done_q   <= rx_done_d;
      frame_err_q <= frame_err_d;
      sync_q      <= sync_d;
    end
  end

  // Frame recovery FSM; everything except the start-edge check waits for a baud tick.
  always_comb begin
    state_d     = state_q;
    s_d         = s_q;
    n_d         = n_q;
    sh_d        = sh_q;
    d_out_d     = d_out_q;
    rx_done_d   = 1'b0;
    frame_err_d = frame_err_q;
    case (state_q)
      IDLE: begin
        if (!rx_s) begin
          s_d     = 4'd0;
          state_d = START;
        end else begin
          state_d = IDLE;
        end
      end
      START: begin
        if (baud) begin
          if (s_q == S_MID) begin
            if (!rx_s) begin
              s_d     = 4'd0;
              n_d     = '0;
              state_d = DATA;
            end else begin
              state_d = IDLE;
            end
          end else begin
            s_d = s_q + 4'd1;
          end
        end else begin
          s_d = s_q;
        end
      end
      DATA: begin
        if (baud) begin
          if (s_q == S_LAST) begin
            s_d  = 4'd0;
            sh_d = {rx_s, sh_q[DBIT-1:1]};
            if (n_q == N_LAST) begin
              state_d = STOP;
            end else begin
              n_d = n_q + NW'(1);
            end
          end else begin
            s_d = s_q + 4'd1;
          end
        end else begin
          s_d = s_q;
        end
      end
      STOP: begin
        if (baud) begin
          if (s_q == S_STOP) begin
            d_out_d     = sh_q;
            rx_done_d   = 1'b1;
            frame_err_d = ~rx_s;
            state_d     = IDLE;
          end else begin
            s_d = s_q + 4'd1;
          end
        end else begin
          s_d = s_q;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign d_out     = d_out_q;
  assign rx_done   = rx_done_q;
  assign frame_err = frame_err_q;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: one thread drives rx/baud and records every
// rx_done strobe; expected bytes/flags come from the serial frames it sent.
module tb_uart_rx;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       baud;
  logic       rx;
  logic [7:0] d_out;
  logic       rx_done;
  logic       frame_err;

  int         tests_run    = 0;
  int         tests_failed = 0;
  int         stepn        = 0;
  logic [1:0] bcnt         = 2'd0;
  bit         baud_en      = 1'b1;
  int         lat_base     = 611;

  int         done_t[$];
  logic [7:0] done_d[$];
  logic       done_e[$];

  // Nominal latency: 2 sync cycles + 9.5 bit periods (mid stop bit) of 64 clk, +/- one tick.
  localparam int LAT_LO = 2 + 9 * 64 + 32 - 4;
  localparam int LAT_HI = 2 + 9 * 64 + 32 + 4;

  always #5 clk = ~clk;

  uart_rx #(.DBIT(8), .SB_TICK(16)) dut (
    .clk(clk), .reset_n(reset_n), .baud(baud), .rx(rx),
    .d_out(d_out), .rx_done(rx_done), .frame_err(frame_err)
  );

  // One clock step: log any strobe, then advance the 1-in-4 baud generator.
  task automatic step();
    @(negedge clk);
    stepn++;
    if (rx_done === 1'b1) begin
      done_t.push_back(stepn);
      done_d.push_back(d_out);
      done_e.push_back(frame_err);
    end
    if (baud_en) begin
      bcnt = bcnt + 2'd1;
      baud = (bcnt == 2'd0);
    end else begin
      baud = 1'b0;
    end
  endtask

  task automatic flush();
    done_t.delete();
    done_d.delete();
    done_e.delete();
  endtask

  task automatic align();
    int k = 0;
    while (bcnt != 2'd2 && k < 8) begin
      step();
      k++;
    end
  endtask

  // Sends frame bits [0..nbits-1] of {stop, data, start}, 64 clk each; optional baud stall.
  task automatic send_frame(input logic [7:0] data, input logic stop, input int stall_bit,
                            input int nbits, output int t0);
    logic [9:0] fr;
    fr = {stop, data, 1'b0};
    align();
    t0 = stepn;
    for (int i = 0; i < nbits; i++) begin
      rx = fr[i];
      if (i == stall_bit) begin
        repeat (10) step();
        baud_en = 1'b0;
        repeat (200) step();
        baud_en = 1'b1;
        repeat (54) step();
      end else begin
        repeat (64) step();
      end
    end
  endtask

  task automatic check_one(input string nm, input logic [7:0] exp_d, input logic exp_e,
                           input int t0, input int lat_lo, input int lat_hi);
    tests_run++;
    if (done_t.size() !== 1) begin
      tests_failed++;
      $display("FAIL %s_count: got %0d strobes expected 1", nm, done_t.size());
    end else begin
      tests_run += 2;
      if (done_d[0] !== exp_d) begin
        tests_failed++;
        $display("FAIL %s_data: got %h expected %h", nm, done_d[0], exp_d);
      end
      if (done_e[0] !== exp_e) begin
        tests_failed++;
        $display("FAIL %s_ferr: got %b expected %b", nm, done_e[0], exp_e);
      end
      tests_run++;
      if (done_t[0] - t0 < lat_lo || done_t[0] - t0 > lat_hi) begin
        tests_failed++;
        $display("FAIL %s_latency: got %0d expected %0d..%0d", nm, done_t[0] - t0, lat_lo, lat_hi);
      end
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    rx      = 1'b1;
    baud    = 1'b0;
    repeat (5) step();
    tests_run += 3;
    if (d_out !== 8'h00) begin tests_failed++; $display("FAIL reset_d_out: got %h expected 00", d_out); end
    if (rx_done !== 1'b0) begin tests_failed++; $display("FAIL reset_rx_done: got %b expected 0", rx_done); end
    if (frame_err !== 1'b0) begin tests_failed++; $display("FAIL reset_frame_err: got %b expected 0", frame_err); end
    reset_n = 1'b1;
    repeat (40) step();
    tests_run++;
    if (done_t.size() !== 0) begin tests_failed++; $display("FAIL reset_idle: got %0d strobes expected 0", done_t.size()); end
  endtask

  task automatic test_basic();
    int t0;
    flush();
    send_frame(8'h55, 1'b1, -1, 10, t0);
    check_one("basic55", 8'h55, 1'b0, t0, LAT_LO, LAT_HI);
    if (done_t.size() == 1) lat_base = done_t[0] - t0;
    repeat (64) step();
    tests_run++;
    if (done_t.size() !== 1) begin tests_failed++; $display("FAIL basic_single_pulse: got %0d strobes expected 1", done_t.size()); end
  endtask

  task automatic test_glitch();
    int t0;
    flush();
    align();
    rx = 1'b0;
    repeat (16) step();
    rx = 1'b1;
    repeat (128) step();
    tests_run++;
    if (done_t.size() !== 0) begin tests_failed++; $display("FAIL glitch_no_strobe: got %0d strobes expected 0", done_t.size()); end
    send_frame(8'hA3, 1'b1, -1, 10, t0);
    check_one("glitch_a3", 8'hA3, 1'b0, t0, LAT_LO, LAT_HI);
  endtask

  task automatic test_frame_err();
    int t0;
    flush();
    send_frame(8'hC3, 1'b0, -1, 10, t0);
    rx = 1'b1;
    tests_run += 3;
    if (done_t.size() < 1) begin
      tests_failed++;
      $display("FAIL ferr_count: got 0 strobes expected >=1");
    end else begin
      if (done_d[0] !== 8'hC3) begin tests_failed++; $display("FAIL ferr_data: got %h expected c3", done_d[0]); end
      if (done_e[0] !== 1'b1) begin tests_failed++; $display("FAIL ferr_flag: got %b expected 1", done_e[0]); end
    end
    if (frame_err !== 1'b1) begin tests_failed++; $display("FAIL ferr_hold: got %b expected 1", frame_err); end
    repeat (704) step();
    flush();
    send_frame(8'h3C, 1'b1, -1, 10, t0);
    check_one("ferr_clear", 8'h3C, 1'b0, t0, LAT_LO, LAT_HI);
    tests_run++;
    if (frame_err !== 1'b0) begin tests_failed++; $display("FAIL ferr_cleared: got %b expected 0", frame_err); end
  endtask

  task automatic test_back_to_back();
    int t0, t1;
    flush();
    send_frame(8'h00, 1'b1, -1, 10, t0);
    send_frame(8'hFF, 1'b1, -1, 10, t1);
    tests_run++;
    if (done_t.size() !== 2) begin
      tests_failed++;
      $display("FAIL b2b_count: got %0d strobes expected 2", done_t.size());
    end else begin
      tests_run += 5;
      if (done_d[0] !== 8'h00) begin tests_failed++; $display("FAIL b2b_data0: got %h expected 00", done_d[0]); end
      if (done_d[1] !== 8'hFF) begin tests_failed++; $display("FAIL b2b_data1: got %h expected ff", done_d[1]); end
      if (done_e[0] !== 1'b0) begin tests_failed++; $display("FAIL b2b_ferr0: got %b expected 0", done_e[0]); end
      if (done_e[1] !== 1'b0) begin tests_failed++; $display("FAIL b2b_ferr1: got %b expected 0", done_e[1]); end
      if (done_t[1] - done_t[0] !== 640) begin
        tests_failed++;
        $display("FAIL b2b_spacing: got %0d expected 640", done_t[1] - done_t[0]);
      end
    end
  endtask

  task automatic test_reset_mid();
    int t0;
    logic [7:0] v;
    v = 8'h96;
    flush();
    send_frame(v, 1'b1, -1, 5, t0);
    rx = v[4];
    repeat (10) step();
    reset_n = 1'b0;
    #1;
    tests_run += 3;
    if (d_out !== 8'h00) begin tests_failed++; $display("FAIL rstmid_d_out: got %h expected 00", d_out); end
    if (rx_done !== 1'b0) begin tests_failed++; $display("FAIL rstmid_rx_done: got %b expected 0", rx_done); end
    if (frame_err !== 1'b0) begin tests_failed++; $display("FAIL rstmid_frame_err: got %b expected 0", frame_err); end
    repeat (3) step();
    reset_n = 1'b1;
    rx      = 1'b1;
    repeat (700) step();
    tests_run++;
    if (done_t.size() !== 0) begin tests_failed++; $display("FAIL rstmid_no_strobe: got %0d strobes expected 0", done_t.size()); end
    send_frame(v, 1'b1, -1, 10, t0);
    check_one("rstmid_96", v, 1'b0, t0, LAT_LO, LAT_HI);
  endtask

  task automatic test_baud_stall();
    int t0;
    flush();
    send_frame(8'h5A, 1'b1, 3, 10, t0);
    check_one("stall_5a", 8'h5A, 1'b0, t0, LAT_LO + 200, LAT_HI + 200);
    tests_run++;
    if (done_t.size() != 1 || done_t[0] - t0 !== lat_base + 200) begin
      tests_failed++;
      $display("FAIL stall_delay: got %0d expected %0d", (done_t.size() == 1) ? done_t[0] - t0 : -1, lat_base + 200);
    end
  endtask

  task automatic test_random();
    logic [7:0] exp_d[$];
    int         start_t[$];
    int         t0;
    logic [7:0] v;
    flush();
    for (int i = 0; i < 8; i++) begin
      v = 8'($urandom);
      repeat ($urandom_range(0, 40)) step();
      send_frame(v, 1'b1, -1, 10, t0);
      exp_d.push_back(v);
      start_t.push_back(t0);
    end
    repeat (64) step();
    tests_run++;
    if (done_t.size() !== exp_d.size()) begin
      tests_failed++;
      $display("FAIL rand_count: got %0d strobes expected %0d", done_t.size(), exp_d.size());
    end else begin
      for (int i = 0; i < exp_d.size(); i++) begin
        tests_run += 3;
        if (done_d[i] !== exp_d[i]) begin
          tests_failed++;
          $display("FAIL rand_data[%0d]: got %h expected %h", i, done_d[i], exp_d[i]);
        end
        if (done_e[i] !== 1'b0) begin
          tests_failed++;
          $display("FAIL rand_ferr[%0d]: got %b expected 0", i, done_e[i]);
        end
        if (done_t[i] - start_t[i] < LAT_LO || done_t[i] - start_t[i] > LAT_HI) begin
          tests_failed++;
          $display("FAIL rand_latency[%0d]: got %0d expected %0d..%0d", i, done_t[i] - start_t[i], LAT_LO, LAT_HI);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_glitch();
    test_frame_err();
    test_back_to_back();
    test_reset_mid();
    test_baud_stall();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL timeout: simulation did not complete, expected finish before 5000000");
    $fatal(1);
  end

endmodule
